// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver plus the received byte,
// the completion/error pulses and the busy flag coming back out.
interface uart_rx_if;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rs232_rx,
    input  rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    input  rs232_rx,
    output rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, centres on the start bit and
// samples each data/stop bit mid-period, flagging a low stop bit as a framing error.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam logic [15:0] HALF    = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_CT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state, state_n;
  logic        sync1, rx_s;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_q, data_n;
  logic        valid_q, valid_n;
  logic        ferr_q, ferr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1   <= bus.rs232_rx;
      rx_s    <= sync1;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_q;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      IDLE: begin
        cnt_n     = 16'd0;
        bit_idx_n = 3'd0;
        if (!rx_s) state_n = START;
      end

      // A start bit that is high again at its midpoint was only a glitch.
      START: begin
        if (cnt == HALF) begin
          cnt_n   = 16'd0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      DATA: begin
        if (cnt == LAST_CT) begin
          shift_n[bit_idx] = rx_s;
          cnt_n            = 16'd0;
          bit_idx_n        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      STOP: begin
        if (cnt == LAST_CT) begin
          cnt_n = 16'd0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end

      // Wait out a held-low line so it cannot be mistaken for new start bits.
      BREAK: begin
        cnt_n = 16'd0;
        if (rx_s) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = 16'd0;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: directed frames push expected
// pulses into a queue and a negedge monitor pops and compares them as they appear.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  uart_rx_if bus_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic sendBit(input logic v, input int n);
    bus_if.rs232_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Sends one well-formed frame; jitter lengthens every odd data bit by that many clocks.
  task automatic applyStimulus(input logic [7:0] data, input int base, input int jitter,
                               input bit check_lat);
    exp_t e;
    e.is_err  = 1'b0;
    e.data    = data;
    e.exp_cyc = check_lat ? (cyc + 1 + 3 + HALF + 9 * CPB) : -1;
    sb.push_back(e);
    sendBit(1'b0, base);
    for (int i = 0; i < 8; i++) sendBit(data[i], base + ((i % 2 == 1) ? jitter : 0));
    sendBit(1'b1, base);
  endtask

  always @(negedge clk) begin
    if (bus_if.rx_valid && bus_if.frame_err)
      checkOutput("pulse_exclusive", 1, 0);
    if (bus_if.rx_valid || bus_if.frame_err) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", {bus_if.rx_valid, bus_if.frame_err}, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pulse_kind_err", int'(bus_if.frame_err), int'(mon_e.is_err));
        checkOutput("rx_data", int'(bus_if.rx_data), int'(mon_e.data));
        if (mon_e.exp_cyc >= 0)
          checkOutput("latency_cycle", cyc, mon_e.exp_cyc);
      end
    end
  end

  initial begin
    int         busy_cnt;
    logic [7:0] byte_v;
    exp_t       e;

    bus_if.rs232_rx = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_rx_data", int'(bus_if.rx_data), 8'h00);
    checkOutput("reset_rx_valid", int'(bus_if.rx_valid), 0);
    checkOutput("reset_frame_err", int'(bus_if.frame_err), 0);
    checkOutput("reset_busy", int'(bus_if.busy), 0);
    rst = 1'b0;
    sendBit(1'b1, 2 * CPB);

    $display("[TB] single frame 0xA5 with latency check");
    applyStimulus(8'hA5, CPB, 0, 1'b1);
    sendBit(1'b1, CPB);

    $display("[TB] back-to-back frames 0x00 0xFF 0x3C");
    applyStimulus(8'h00, CPB, 0, 1'b1);
    applyStimulus(8'hFF, CPB, 0, 1'b1);
    applyStimulus(8'h3C, CPB, 0, 1'b1);
    sendBit(1'b1, 2 * CPB);

    $display("[TB] 4-clock glitch on idle line");
    busy_cnt = 0;
    bus_if.rs232_rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.busy) busy_cnt++;
    end
    bus_if.rs232_rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_if.busy) busy_cnt++;
    end
    checkOutput("glitch_busy_le9", int'(busy_cnt <= 9), 1);
    checkOutput("glitch_busy_seen", int'(busy_cnt > 0), 1);
    checkOutput("glitch_idle_after", int'(bus_if.busy), 0);

    $display("[TB] 0x55 with low stop bit and held break");
    e.is_err  = 1'b1;
    e.data    = 8'h3C;
    e.exp_cyc = -1;
    sb.push_back(e);
    byte_v = 8'h55;
    sendBit(1'b0, CPB);
    for (int i = 0; i < 8; i++) sendBit(byte_v[i], CPB);
    sendBit(1'b0, 40 * CPB);
    checkOutput("break_busy_held", int'(bus_if.busy), 1);
    checkOutput("break_data_kept", int'(bus_if.rx_data), 8'h3C);
    sendBit(1'b1, 4);
    checkOutput("break_busy_release", int'(bus_if.busy), 0);
    sendBit(1'b1, CPB);
    applyStimulus(8'h81, CPB, 0, 1'b1);
    sendBit(1'b1, CPB);

    $display("[TB] reset during data bit 4 of 0x96");
    byte_v = 8'h96;
    sendBit(1'b0, CPB);
    for (int i = 0; i < 4; i++) sendBit(byte_v[i], CPB);
    sendBit(byte_v[4], CPB / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_rx_data", int'(bus_if.rx_data), 8'h00);
    checkOutput("midreset_rx_valid", int'(bus_if.rx_valid), 0);
    checkOutput("midreset_frame_err", int'(bus_if.frame_err), 0);
    checkOutput("midreset_busy", int'(bus_if.busy), 0);
    sendBit(1'b1, 2 * CPB);
    applyStimulus(8'h42, CPB, 0, 1'b1);
    sendBit(1'b1, CPB);

    $display("[TB] jittered bit periods with 0xC3");
    applyStimulus(8'hC3, CPB - 1, 1, 1'b0);
    sendBit(1'b1, CPB);
    applyStimulus(8'hC3, CPB, 1, 1'b0);
    sendBit(1'b1, 2 * CPB);

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, giving clocks per serial bit period (legal range 4..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rs232_rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-006 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL receive frames of 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with no parity.
REQ-010 SHALL pass rs232_rx through a 2-flop synchronizer (both flops reset to 1); all decisions SHALL use the second flop output (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK with a 16-bit bit counter and a 3-bit bit index.
REQ-012 In IDLE: counter and bit index held at 0; when rx_s==0, next state SHALL be START.
REQ-013 In START: counter SHALL increment each cycle. At counter==HALF (HALF=(CLKS_PER_BIT-1)/2, integer division), rx_s==0 SHALL go to DATA with counter 0. rx_s==1 SHALL go to IDLE as a glitch, with no output pulse.
REQ-014 In DATA: at counter==CLKS_PER_BIT-1, rx_s SHALL be shifted into the data register at position bit index, the counter cleared and the bit index incremented. After bit index 7 is sampled, next state SHALL be STOP with the bit index wrapped to 0.
REQ-015 In STOP: at counter==CLKS_PER_BIT-1, rx_s==1 SHALL load rx_data from the shift register, pulse rx_valid for exactly 1 cycle and go to IDLE.
REQ-016 In STOP: at counter==CLKS_PER_BIT-1, rx_s==0 SHALL pulse frame_err for 1 cycle, leave rx_data unchanged and go to BREAK.
REQ-017 In BREAK: SHALL stay until rx_s==1, then go to IDLE; a held-low line SHALL produce no further pulses.
REQ-018 rx_valid and frame_err SHALL never be high in the same cycle.
REQ-019 Latency: if rs232_rx is first low at clock edge 0 and the frame is valid, rx_valid SHALL be high during the cycle following edge 3+HALF+9*CLKS_PER_BIT.
REQ-020 A start bit beginning immediately after a stop bit (back-to-back frames) SHALL be received. Stop sampling occurs mid-bit, so IDLE is re-entered before the next falling edge.
REQ-021 rx_data SHALL hold its value until the next valid frame; the register is not cleared on read or on error.
REQ-022 Counter arithmetic SHALL be unsigned 16-bit, and the counter SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-023 rst high at a clock edge SHALL force state IDLE, counter 0, bit index 0, shift register 0x00, rx_data 0x00, rx_valid 0, frame_err 0, busy 0 and synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err. After release, reception SHALL resume at the next falling edge of rx_s.

Verification (bench uses CLKS_PER_BIT=16, HALF=7)
REQ-025 SHALL check: frame 0xA5 at 16 clk/bit -> single rx_valid pulse at edge 154 after start, rx_data=0xA5, frame_err never high.
REQ-026 SHALL check: frames 0x00, 0xFF and 0x3C sent back-to-back with no idle gap -> three rx_valid pulses, rx_data sequence 0x00, 0xFF, 0x3C.
REQ-027 SHALL check: 4-clock low glitch on an idle line -> return to IDLE by mid-start, no rx_valid, no frame_err, busy high for at most 9 cycles.
REQ-028 SHALL check: frame 0x55 with the stop bit driven 0 and the line held low 40 bit times -> one frame_err pulse, rx_data keeps its prior value, busy high until the line returns to 1, then a 0x81 frame is received correctly.
REQ-029 SHALL check: rst pulsed during data bit 4 of frame 0x96 -> all outputs at reset values, no pulse; the next frame 0x42 gives rx_data=0x42.
REQ-030 SHALL check: a frame at bit period ±3% (15.5 or 16.5 clk average, via jittered edges) with byte 0xC3 -> rx_data=0xC3.
